dmem_ctrl: RTL and testbench

- Parametrised single-clock data memory controller; successor to the 32-bit word-only data RAM with an upload mux.
- Adds byte/half/word loads and stores with sign/zero extension, misalignment detection, and an optional post-reset zero-clear sequencer.
- Adds a mode FSM arbitrating between the CPU port and the UART upload (upg) port.
- Sits between the CPU MEM stage and an inferred per-byte-lane RAM array; no vendor IP.

---
 rtl/dmem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl : byte/half/word data RAM controller with zero-clear and upload
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module dmem_ctrl #(
  parameter int DEPTH_LOG2     = 14,
  parameter int ADDR_W         = DEPTH_LOG2 + 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  ram_clk_i,
  input  logic                  ram_rst_n_i,
  input  logic                  ram_req_i,
  input  logic                  ram_wen_i,
  input  logic [1:0]            ram_size_i,
  input  logic                  ram_unsigned_i,
  input  logic [ADDR_W-1:0]     ram_adr_i,
  input  logic [31:0]           ram_dat_i,
  output logic [31:0]           ram_dat_o,
  output logic                  ram_vld_o,
  output logic                  ram_ready_o,
  output logic                  ram_misalign_o,
  input  logic                  upg_en_i,
  input  logic                  upg_wen_i,
  input  logic [DEPTH_LOG2-1:0] upg_adr_i,
  input  logic [31:0]           upg_dat_i,
  input  logic                  upg_done_i,
  output logic [1:0]            mode_o
);

  localparam int                    c_depth     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] c_last_word = '1;
  localparam logic [DEPTH_LOG2-1:0] c_one       = 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'b00,
    S_LOAD  = 2'b01,
    S_RUN   = 2'b10
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic                  w_ready, w_accept, w_misal, w_rd_en;
  logic [3:0]            w_we;
  logic [DEPTH_LOG2-1:0] w_wadr, w_radr;
  logic [31:0]           w_wdat, w_rd_word, w_ext;
  logic [7:0]            w_lane8;
  logic [15:0]           w_lane16;
  logic                  r_vld, r_mis, r_drop, r_uns;
  logic [1:0]            r_lo, r_size;

  assign w_radr   = ram_adr_i[2 +: DEPTH_LOG2];
  assign w_accept = w_ready & ram_req_i;
  assign w_rd_en  = w_accept & ~ram_wen_i;

  always_comb begin
    w_misal = 1'b0;
    case (ram_size_i)
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = ram_adr_i[0];
      2'b10:   w_misal = (ram_adr_i[1:0] != 2'b00);
      default: w_misal = 1'b1;
    endcase
  end

  always_ff @(posedge ram_clk_i) begin
    if (!ram_rst_n_i) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the single RAM write port shared by clear, upload and CPU stores.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_we        = 4'b0000;
    w_wadr      = w_radr;
    w_wdat      = ram_dat_i;
    case (r_state)
      S_CLEAR: begin
        w_we   = 4'b1111;
        w_wadr = r_cnt;
        w_wdat = '0;
        if (r_cnt == c_last_word) begin
          w_state_nxt = upg_en_i ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        if (upg_wen_i) begin
          w_we   = 4'b1111;
          w_wadr = upg_adr_i;
          w_wdat = upg_dat_i;
        end
        if (upg_done_i) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_ready = 1'b1;
        if (ram_req_i) begin
          if (ram_wen_i && !w_misal) begin
            case (ram_size_i)
              2'b00: begin
                w_we   = 4'b0001 << ram_adr_i[1:0];
                w_wdat = {4{ram_dat_i[7:0]}};
              end
              2'b01: begin
                w_we   = ram_adr_i[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{ram_dat_i[15:0]}};
              end
              default: w_we = 4'b1111;
            endcase
          end
        end else if (upg_en_i) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
    // Memory must survive reset when the clear sequencer is disabled.
    if (!ram_rst_n_i) begin
      w_we    = 4'b0000;
      w_ready = 1'b0;
    end
  end

  always_ff @(posedge ram_clk_i) begin
    if (!ram_rst_n_i) begin
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_mis  <= 1'b0;
      r_drop <= 1'b0;
      r_uns  <= 1'b0;
      r_lo   <= 2'b00;
      r_size <= 2'b00;
    end else begin
      if (r_state == S_CLEAR) begin
        r_cnt <= r_cnt + c_one;
      end
      r_vld <= w_rd_en;
      if (w_accept && w_misal) begin
        r_mis <= 1'b1;
      end
      if (w_rd_en) begin
        r_drop <= w_misal;
        r_uns  <= ram_unsigned_i;
        r_lo   <= ram_adr_i[1:0];
        r_size <= ram_size_i;
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] r_mem [c_depth];
    logic [7:0] r_rd;

    always_ff @(posedge ram_clk_i) begin
      if (w_we[i]) begin
        r_mem[w_wadr] <= w_wdat[8*i +: 8];
      end
    end

    always_ff @(posedge ram_clk_i) begin
      if (!ram_rst_n_i) begin
        r_rd <= '0;
      end else if (w_rd_en) begin
        r_rd <= r_mem[w_radr];
      end
    end

    assign w_rd_word[8*i +: 8] = r_rd;
  end

  // Lane select and extension act on load-time registers, so the output holds between loads.
  always_comb begin
    w_lane8  = w_rd_word[{r_lo, 3'b000} +: 8];
    w_lane16 = r_lo[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    w_ext    = '0;
    case (r_size)
      2'b00:   w_ext = r_uns ? {24'h0, w_lane8}  : {{24{w_lane8[7]}}, w_lane8};
      2'b01:   w_ext = r_uns ? {16'h0, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
      2'b10:   w_ext = w_rd_word;
      default: w_ext = '0;
    endcase
    if (r_drop) begin
      w_ext = '0;
    end
  end

  assign ram_dat_o      = w_ext;
  assign ram_vld_o      = r_vld;
  assign ram_ready_o    = w_ready;
  assign ram_misalign_o = r_mis;
  assign mode_o         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_ctrl : scoreboard bench for dmem_ctrl (DEPTH_LOG2=4, clear on reset)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_ctrl;

  localparam int DEPTH_LOG2 = 4;
  localparam int ADDR_W     = 6;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SR = 2'b11;

  logic                  clk = 1'b0;
  logic                  ram_rst_n_i = 1'b0;
  logic                  ram_req_i = 1'b0, ram_wen_i = 1'b0, ram_unsigned_i = 1'b0;
  logic [1:0]            ram_size_i = 2'b00;
  logic [ADDR_W-1:0]     ram_adr_i = '0;
  logic [31:0]           ram_dat_i = '0;
  logic [31:0]           ram_dat_o;
  logic                  ram_vld_o, ram_ready_o, ram_misalign_o;
  logic                  upg_en_i = 1'b0, upg_wen_i = 1'b0, upg_done_i = 1'b0;
  logic [DEPTH_LOG2-1:0] upg_adr_i = '0;
  logic [31:0]           upg_dat_i = '0;
  logic [1:0]            mode_o;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_ctrl #(
    .DEPTH_LOG2    (DEPTH_LOG2),
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .ram_clk_i     (clk),
    .ram_rst_n_i   (ram_rst_n_i),
    .ram_req_i     (ram_req_i),
    .ram_wen_i     (ram_wen_i),
    .ram_size_i    (ram_size_i),
    .ram_unsigned_i(ram_unsigned_i),
    .ram_adr_i     (ram_adr_i),
    .ram_dat_i     (ram_dat_i),
    .ram_dat_o     (ram_dat_o),
    .ram_vld_o     (ram_vld_o),
    .ram_ready_o   (ram_ready_o),
    .ram_misalign_o(ram_misalign_o),
    .upg_en_i      (upg_en_i),
    .upg_wen_i     (upg_wen_i),
    .upg_adr_i     (upg_adr_i),
    .upg_dat_i     (upg_dat_i),
    .upg_done_i    (upg_done_i),
    .mode_o        (mode_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  // Every valid pulse consumes one expected load result.
  always @(posedge clk) begin
    #1;
    if (ram_vld_o === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_vld", 32'(ram_vld_o), 32'd0);
      else                   chk("load_data", ram_dat_o, exp_q.pop_front());
    end
  end

  // Called at a falling edge; returns at the next falling edge with the request dropped.
  task automatic cpu(input logic w, input logic [1:0] sz, input logic u,
                     input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [31:0] e);
    chk("ready", 32'(ram_ready_o), 32'd1);
    ram_req_i = 1'b1; ram_wen_i = w; ram_size_i = sz; ram_unsigned_i = u;
    ram_adr_i = a; ram_dat_i = d;
    if (!w) exp_q.push_back(e);
    @(negedge clk);
    ram_req_i = 1'b0; ram_wen_i = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_dat",   ram_dat_o, 32'd0);
    chk("rst_vld",   32'(ram_vld_o), 32'd0);
    chk("rst_ready", 32'(ram_ready_o), 32'd0);
    chk("rst_mis",   32'(ram_misalign_o), 32'd0);
    chk("rst_mode",  32'(mode_o), 32'd0);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (mode_o !== 2'b10 && n < 64);
    chk(tag, 32'(n), 32'd16);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    ram_rst_n_i = 1'b1;
    wait_run("clear_len");

    cpu(1'b0, SW, 1'b0, 6'h3C, 32'h0, 32'h0);
    chk("vld_latency", 32'(ram_vld_o), 32'd1);
    @(negedge clk);
    chk("vld_one_cycle", 32'(ram_vld_o), 32'd0);

    cpu(1'b1, SW, 1'b0, 6'h08, 32'h80FF7F01, 32'h0);
    cpu(1'b0, SB, 1'b0, 6'h08, 32'h0, 32'h00000001);
    cpu(1'b0, SB, 1'b0, 6'h0B, 32'h0, 32'hFFFFFF80);
    cpu(1'b0, SB, 1'b1, 6'h0B, 32'h0, 32'h00000080);
    cpu(1'b0, SH, 1'b0, 6'h0A, 32'h0, 32'hFFFF80FF);
    cpu(1'b0, SH, 1'b1, 6'h08, 32'h0, 32'h00007F01);
    cpu(1'b0, SW, 1'b0, 6'h08, 32'h0, 32'h80FF7F01);
    cpu(1'b0, SH, 1'b1, 6'h0A, 32'h0, 32'h000080FF);
    @(negedge clk);
    chk("dat_hold", ram_dat_o, 32'h000080FF);

    cpu(1'b1, SW, 1'b0, 6'h0C, 32'h11223344, 32'h0);
    cpu(1'b1, SB, 1'b0, 6'h0D, 32'hFFFFFFAB, 32'h0);
    cpu(1'b0, SW, 1'b0, 6'h0C, 32'h0, 32'h1122AB44);
    cpu(1'b1, SW, 1'b0, 6'h10, 32'h0, 32'h0);
    cpu(1'b1, SH, 1'b0, 6'h12, 32'h1234CAFE, 32'h0);
    cpu(1'b0, SW, 1'b0, 6'h10, 32'h0, 32'hCAFE0000);
    cpu(1'b0, SH, 1'b0, 6'h12, 32'h0, 32'hFFFFCAFE);
    cpu(1'b1, SH, 1'b0, 6'h10, 32'h99995A5A, 32'h0);
    cpu(1'b0, SW, 1'b0, 6'h10, 32'h0, 32'hCAFE5A5A);

    chk("mis_clear", 32'(ram_misalign_o), 32'd0);
    cpu(1'b1, SW, 1'b0, 6'h04, 32'h55667788, 32'h0);
    cpu(1'b0, SW, 1'b0, 6'h06, 32'h0, 32'h0);
    chk("mis_set", 32'(ram_misalign_o), 32'd1);
    cpu(1'b1, SW, 1'b0, 6'h05, 32'h12345678, 32'h0);
    cpu(1'b0, SH, 1'b0, 6'h05, 32'h0, 32'h0);
    cpu(1'b0, SR, 1'b0, 6'h04, 32'h0, 32'h0);
    cpu(1'b0, SW, 1'b0, 6'h04, 32'h0, 32'h55667788);
    @(negedge clk);
    chk("mis_sticky", 32'(ram_misalign_o), 32'd1);

    // Upload strobes outside LOAD must have no effect.
    upg_wen_i = 1'b1; upg_adr_i = 4'd5; upg_dat_i = 32'hFFFFFFFF; upg_done_i = 1'b1;
    @(negedge clk);
    upg_wen_i = 1'b0; upg_done_i = 1'b0;
    chk("run_stays", 32'(mode_o), 32'd2);
    cpu(1'b0, SW, 1'b0, 6'h14, 32'h0, 32'h0);

    upg_en_i = 1'b1;
    @(negedge clk);
    chk("load_ready", 32'(ram_ready_o), 32'd0);
    chk("load_mode", 32'(mode_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      upg_wen_i = 1'b1; upg_adr_i = 4'(i); upg_dat_i = 32'hA0 + 32'(i);
      upg_done_i = (i == 3);
      ram_req_i = 1'b1; ram_wen_i = 1'b1; ram_size_i = SW; ram_adr_i = 6'h10;
      ram_dat_i = 32'hDEADBEEF;
      @(negedge clk);
    end
    upg_wen_i = 1'b0; upg_done_i = 1'b0; upg_en_i = 1'b0;
    ram_req_i = 1'b0; ram_wen_i = 1'b0;
    chk("upload_done_mode", 32'(mode_o), 32'd2);
    cpu(1'b0, SW, 1'b0, 6'h0C, 32'h0, 32'h000000A3);
    cpu(1'b0, SW, 1'b0, 6'h00, 32'h0, 32'h000000A0);
    cpu(1'b0, SW, 1'b0, 6'h10, 32'h0, 32'hCAFE5A5A);
    repeat (2) @(negedge clk);

    ram_rst_n_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    ram_rst_n_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("clear_mid", 32'(mode_o), 32'd0);
    ram_rst_n_i = 1'b0;
    @(negedge clk);
    ram_rst_n_i = 1'b1;
    wait_run("clear_restart");
    cpu(1'b0, SW, 1'b0, 6'h0C, 32'h0, 32'h0);
    cpu(1'b0, SW, 1'b0, 6'h3C, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("pending_loads", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
